// File: rtl/logic_unit_seq_if.sv
// logic_unit_seq_if
// -----------------
// Bundles the request and result signals of the sliced logic unit.
//   master : drives start, op, A, B; observes S, busy, done, zero, op_err, dbg_state.
//   slave  : the logic unit itself (the opposite directions).
//
// Handshake: start is a request that the unit samples only while it is idle.
// An accepted start latches op/A/B. busy is high for the N cycles of work.
// done is a single-cycle pulse marking a fresh S. busy and done are never
// high together, and a new request is first accepted in the idle cycle
// that follows done.
interface logic_unit_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             busy;
  logic             done;
  logic             zero;
  logic             op_err;
  logic [1:0]       dbg_state;  // current FSM state, for observation only

  modport master (
    output start, op, A, B,
    input  S, busy, done, zero, op_err, dbg_state
  );

  modport slave (
    input  start, op, A, B,
    output S, busy, done, zero, op_err, dbg_state
  );
endinterface

// File: rtl/logic_unit_seq.sv
// logic_unit_seq
// --------------
// Multi-cycle bitwise logic unit. It handles SLICE bits per clock over
// N = WIDTH/SLICE cycles and supports eight opcodes:
//   000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A,
//   111 invalid (result 0, op_err=1).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of logic_unit_seq_if. It carries start/op/A/B in and
//           S/busy/done/zero/op_err/dbg_state out.
// WIDTH must be a multiple of SLICE, and 1 <= SLICE <= WIDTH.
module logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             reset,
  logic_unit_seq_if.slave  bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             op_err_q, op_err_d;

  // Bit offset of the slice being worked on in this RUN cycle.
  logic [IW-1:0]    base;
  logic [SLICE-1:0] a_sl, b_sl, r_sl;

  assign base = IW'(int'(cnt_q) * SLICE);
  assign a_sl = a_q[base +: SLICE];
  assign b_sl = b_q[base +: SLICE];

  // Only one slice of logic is built; the operand slice is muxed in by cnt.
  always_comb begin
    r_sl = '0;
    case (op_q)
      3'b000:  r_sl = a_sl & b_sl;
      3'b001:  r_sl = a_sl | b_sl;
      3'b010:  r_sl = a_sl ^ b_sl;
      3'b011:  r_sl = ~(a_sl & b_sl);
      3'b100:  r_sl = ~(a_sl | b_sl);
      3'b101:  r_sl = ~(a_sl ^ b_sl);
      3'b110:  r_sl = ~a_sl;
      default: r_sl = '0;  // invalid opcode yields zeros
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    op_err_d = op_err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.A;
          b_d      = bus.B;
          op_d     = bus.op;
          shadow_d = '0;
          cnt_d    = '0;
          op_err_d = (bus.op == 3'b111);
          state_d  = RUN;
        end
      end
      RUN: begin
        shadow_d[base +: SLICE] = r_sl;
        if (cnt_q == CW'(N - 1)) begin
          // shadow_d already includes the final slice written above.
          s_d     = shadow_d;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      shadow_q <= '0;
      s_q      <= '0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      op_err_q <= op_err_d;
    end
  end

  // All outputs are decoded from registers, so they are glitch-free.
  assign bus.S         = s_q;
  assign bus.zero      = (s_q == '0);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.op_err    = op_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
module tb_logic_unit_seq;

  localparam int W  = 8;
  localparam int SL = 2;
  localparam int N  = W / SL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic_unit_seq_if #(.WIDTH(W))  bus();
  logic_unit_seq_if #(.WIDTH(16)) bus16();
  logic_unit_seq_if #(.WIDTH(8))  bus8();

  logic_unit_seq #(.WIDTH(W), .SLICE(SL)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic_unit_seq #(.WIDTH(16), .SLICE(4)) u16 (.clk(clk), .reset(reset), .bus(bus16));
  logic_unit_seq #(.WIDTH(8), .SLICE(8))  u8  (.clk(clk), .reset(reset), .bus(bus8));

  // ---------------- scoreboard state ----------------
  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  int           cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each opcode is a 2-input truth table indexed by {a_i,b_i},
  // applied independently to every bit position.
  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input int w);
    logic [3:0]  tt;
    logic [15:0] r;
    case (op)
      3'd0:    tt = 4'b1000;  // AND
      3'd1:    tt = 4'b1110;  // OR
      3'd2:    tt = 4'b0110;  // XOR
      3'd3:    tt = 4'b0111;  // NAND
      3'd4:    tt = 4'b0001;  // NOR
      3'd5:    tt = 4'b1001;  // XNOR
      3'd6:    tt = 4'b0011;  // NOT A
      default: tt = 4'b0000;  // invalid
    endcase
    r = '0;
    for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int t = 0;
    while ((bus.busy || bus.done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("wait_idle_timeout", 1, 0);
  endtask

  // Issue one request. noise keeps start high with other operands through
  // RUN and DONE, which must all be ignored.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit noise, input bit push);
    wait_idle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    if (push) begin
      exp_q.push_back(ref_op(op, {8'h0, a}, {8'h0, b}, W)[W-1:0]);
      err_q.push_back(op == 3'b111);
      cyc_q.push_back(cyc + 1 + N);
    end
    @(negedge clk);
    check("op_err_on_accept", bus.op_err, (op == 3'b111));
    check("busy_on_accept", bus.busy, 1);
    bus.op = 3'($urandom);
    bus.A  = 8'($urandom);
    bus.B  = 8'($urandom);
    if (noise) begin
      bus.start = 1'b1;
      repeat (N + 1) @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int t;
    logic [15:0] e;
    e = ref_op(op, a, b, 16);
    bus16.start = 1'b1; bus16.op = op; bus16.A = a; bus16.B = b;
    @(negedge clk);
    bus16.start = 1'b0; bus16.A = 16'($urandom); bus16.B = 16'($urandom);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus16.done && t < 40);
    check("u16_latency", t, 4);
    check("u16_S", bus16.S, e);
    check("u16_zero", bus16.zero, (e == 16'h0));
    @(negedge clk);
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    logic [7:0] e;
    e = ref_op(op, {8'h0, a}, {8'h0, b}, 8)[7:0];
    bus8.start = 1'b1; bus8.op = op; bus8.A = a; bus8.B = b;
    @(negedge clk);
    check("u8_busy", bus8.busy, 1);
    bus8.start = 1'b0; bus8.A = 8'($urandom); bus8.B = 8'($urandom);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus8.done && t < 40);
    check("u8_latency", t, 1);
    check("u8_S", bus8.S, e);
    check("u8_op_err", bus8.op_err, (op == 3'b111));
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  int busy_len = 0;
  initial begin
    logic [W-1:0] e;
    logic         ee;
    int           ec;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_len = 0;
      end else begin
        check("busy_done_excl", bus.busy & bus.done, 0);
        if (bus.busy) busy_len++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e  = exp_q.pop_front();
            ee = err_q.pop_front();
            ec = cyc_q.pop_front();
            check("S", bus.S, e);
            check("zero", bus.zero, (e == '0));
            check("op_err", bus.op_err, ee);
            check("done_cycle", cyc, ec);
            check("busy_len", busy_len, N);
          end
          busy_len = 0;
        end else if (!bus.busy) begin
          busy_len = 0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 0;   bus.op = 0;   bus.A = 0;   bus.B = 0;
    bus16.start = 0; bus16.op = 0; bus16.A = 0; bus16.B = 0;
    bus8.start = 0;  bus8.op = 0;  bus8.A = 0;  bus8.B = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_S", bus.S, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_op_err", bus.op_err, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'b001, 8'hA5, 8'h3C, 0, 1);
    issue(3'b010, 8'hFF, 8'hFF, 0, 1);
    issue(3'b011, 8'hF0, 8'hFF, 0, 1);
    issue(3'b000, 8'hCC, 8'hAA, 1, 1);

    // Abort an operation with an asynchronous reset mid-RUN.
    wait_idle();
    issue(3'b100, 8'h0F, 8'h30, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_S", bus.S, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_zero", bus.zero, 1);
    check("abort_op_err", bus.op_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(3'b101, 8'h5A, 8'h5A, 0, 1);
    issue(3'b111, 8'h12, 8'h34, 0, 1);
    issue(3'b110, 8'h0F, 8'($urandom), 0, 1);

    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1);

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    run16(3'b011, 16'hFFFF, 16'h00FF);
    for (int i = 0; i < 6; i++)
      run16(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    run8(3'b001, 8'h01, 8'h80);
    for (int i = 0; i < 6; i++)
      run8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", compared);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the datapath ALU. It generalises the fixed 8-bit single-function OR into a WIDTH-bit, eight-opcode logic block. The block processes SLICE bits per clock, which bounds gate count on narrow fabrics. It uses a start/busy/done handshake so the control FSM can sequence it like the other multi-cycle ALU units. It sits beside the adder/shifter inside the ALU and drives the ALU result mux and the zero flag.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must be a multiple of SLICE.
- SLICE, 2, bits processed per clock; must be between 1 and WIDTH.
- Derived: N = WIDTH/SLICE, the number of RUN cycles. The counter width is clog2(N), minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation select, latched on accepted start.
- A  in  WIDTH  operand A, latched on accepted start.
- B  in  WIDTH  operand B, latched on accepted start.
- S  out  WIDTH  registered result; holds the last completed result.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a new S is valid.
- zero  out  1  high when S == 0.
- op_err  out  1  high when the last accepted op was invalid (111).

## Operation
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT A (B ignored)
  - 111 invalid: result all zeros, op_err=1
- FSM states and transitions:
  - IDLE: start=1 latches A, B and op into internal registers; clears the shadow result and counter; sets op_err = (op==111); goes to RUN. start=0 stays in IDLE.
  - RUN: each cycle computes slice [cnt*SLICE +: SLICE] from the latched operands into the shadow result, then increments cnt. On cnt==N-1, loads the full shadow result (final slice included) into S and goes to DONE.
  - DONE: done=1 for this single cycle; unconditionally returns to IDLE.
- start is ignored in RUN and DONE; there is no queuing. A new start is first accepted in the IDLE cycle after DONE.
- Input changes on A, B and op after acceptance have no effect on the running operation.
- S, zero and op_err change only on completion or reset. op_err is the exception: it updates on acceptance and is held until the next acceptance.
- zero is combinational from the S register (S == 0), so it is glitch-free relative to S.
- Width rule: purely bitwise; there is no carry and no sign handling. Bit i of S depends only on bit i of A and B.

## Timing
- Reset (asynchronous, effective immediately, independent of clk) forces:
  - state=IDLE, cnt=0
  - S=0, busy=0, done=0, zero=1, op_err=0
  - internal latches cleared
- Reset asserted mid-RUN aborts the operation. S keeps its reset value (0), not a partial result.
- First edge after reset deassertion: block is in IDLE and accepts start.
- Latency: start accepted at edge k:
  - busy=1 from edge k until edge k+N.
  - S updates at edge k+N.
  - done=1 from edge k+N until edge k+N+1.
  - Earliest next acceptance is at edge k+N+2.
- Throughput: one operation per N+2 cycles with start held high.
- SLICE=WIDTH (N=1): RUN lasts one cycle; latency is 1 cycle to S, and the FSM still passes through DONE.
- start=1 held continuously: re-accepted at every IDLE, giving back-to-back operations with one IDLE cycle between them.
- done and busy are never high in the same cycle.

## Test plan
- WIDTH=8, SLICE=2. op=001, A=0xA5, B=0x3C, start pulse at edge k. Required response:
  - busy high for 4 cycles.
  - S=0xBD at edge k+4.
  - done high for exactly one cycle.
  - zero=0, op_err=0.
- op=010, A=0xFF, B=0xFF. Required: S=0x00 and zero=1 after 4 cycles. Then op=011, A=0xF0, B=0xFF. Required: S=0x0F and zero=0.
- op=000, A=0xCC, B=0xAA accepted. While busy, apply start with op=001, A=0x00, B=0x00. Required:
  - The second start is ignored.
  - S=0x88.
  - Only one done pulse.
- Start op=100, A=0x0F, B=0x30, then assert reset 2 cycles into RUN. Required:
  - Immediately: S=0, busy=0, done=0, zero=1.
  - After release, a new op=101, A=0x5A, B=0x5A gives S=0xFF.
- op=111, A=0x12, B=0x34. Required: op_err=1 from acceptance, S=0x00 and zero=1 at done. Then op=110, A=0x0F. Required: op_err=0 on acceptance, S=0xF0.
- Parameter sweep:
  - WIDTH=16, SLICE=4, op=011, A=0xFFFF, B=0x00FF. Required: S=0xFF00 after exactly 4 RUN cycles.
  - WIDTH=8, SLICE=8, op=001, A=0x01, B=0x80. Required: S=0x81 one cycle after acceptance.
